sat_accum_16bit: RTL and testbench
==================================

Name: sat_accum_16bit

Overview:
- Sequential saturating accumulator that streams signed 16-bit operands into the 16-bit saturating add/sub stage and consumes its result every cycle.
- Folds a packet of operands into one saturated sum.
- Presents the sum with Z/N/sticky-V flags through a valid/ready result port.
- Sits between the operand source (register read / sequencer) and the flag/writeback logic.

Parameters:
- MAX_BEATS, 16, maximum operands per packet before forced termination (2..255).
- CNT_W, $clog2(MAX_BEATS+1), beat counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat
- in_data  input  16  signed operand
- in_sub  input  1  1: acc - in_data, 0: acc + in_data
- in_last  input  1  final beat of packet
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  16  saturated signed sum
- out_ovfl  output  1  sticky: any beat in packet saturated
- out_zero  output  1  out_data == 0
- out_neg  output  1  out_data[15]
- out_len_err  output  1  packet ended by MAX_BEATS, not in_last
- busy  output  1  packet in progress (ACCUM or DONE)

Behaviour:
- Reset: the synchronous rst_n==0 sample at a clk edge forces:
  - state=IDLE, acc=0, cnt=0;
  - all outputs 0 except in_ready=1.
  - Applies mid-packet; the partial sum is discarded.
- States IDLE, ACCUM, DONE.
- in_ready = (state != DONE). A beat is accepted when in_valid && in_ready at the clk edge.
- Arithmetic:
  - On an accepted beat, nxt = sat(base ± in_data).
  - base = 0 in IDLE, acc in ACCUM.
  - Computed by the addsub stage combinationally, registered into acc at the edge.
- Saturation rules, identical to the addsub stage:
  - add overflow when operands share a sign and the raw sum sign differs;
  - sub overflow when operand signs differ and the raw sign differs from the minuend;
  - positive overflow -> 16'h7FFF, negative overflow -> 16'h8000.
- ovfl_sticky: cleared on the first beat of a packet; ORed with each beat's overflow.
- IDLE:
  - accepted beat without in_last -> ACCUM, cnt=1;
  - accepted beat with in_last -> DONE.
- ACCUM:
  - accepted beat -> cnt++;
  - in_last -> DONE;
  - cnt reaching MAX_BEATS without in_last -> DONE with len_err=1.
  - No accepted beat -> hold (bubbles allowed).
- DONE:
  - out_valid=1; out_data/flags stable and registered.
  - out_valid rises the cycle after the last accepted beat (latency 1).
  - When out_valid && out_ready -> IDLE; out_valid=0 next cycle; acc, cnt, sticky flags and len_err cleared.
  - Outputs held indefinitely under backpressure.
  - in_valid during DONE is ignored; no accept.
- out_zero and out_neg are derived from the registered acc and are meaningful only while out_valid=1.
- Single-beat packet: result = sat(0 ± in_data). 0 - 16'h8000 -> 16'h7FFF with ovfl=1.
- Saturated acc continues accumulating from the clamped value (no wrap).

Decomposition:
- Shared package holds:
  - SAT_POS=16'h7FFF, SAT_NEG=16'h8000;
  - the state enum {IDLE, ACCUM, DONE}.
- One sub-module instance: addsub_16bit (A=base, B=in_data, sub=in_sub, SUM=nxt).
- The overflow bit is recomputed locally from operand/result signs, because addsub_16bit exports only SUM.

Test Plan:
1. Beats 0x0005 add, 0x000A add, 0x0003 sub+last on consecutive cycles -> next cycle out_valid=1, out_data=0x000C, ovfl=0, zero=0, neg=0.
2. Beats 0x7000 add, 0x2000 add+last -> out_data=0x7FFF, ovfl=1; repeat with 0x9000, 0xE000 -> 0x8000, ovfl=1, neg=1.
3. Beats 0x8000 sub, 0x0001 add, 0xFFFF add+last -> 0x7FFF, 0x7FFF, 0x7FFE; out_data=0x7FFE, ovfl=1 (sticky).
4. Result pending with out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0, out_data/flags unchanged, no beats absorbed; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
5. 16 beats of 0x0001 add, never in_last (MAX_BEATS=16) -> out_data=0x0010, out_len_err=1; 0x0000 single beat+last -> zero=1.
6. rst_n=0 for one edge after 2 beats -> state IDLE, all outputs 0, in_ready=1; new packet 0x0004+last -> out_data=0x0004.

Source files
------------

// File: rtl/sat_accum_16bit_pkg.sv
// Shared constants, state encoding and overflow helper for the saturating accumulator.
package sat_accum_16bit_pkg;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Signed overflow of a +/- b given the wrapped result raw.
  function automatic logic sat_ovfl(input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input logic [15:0] raw);
    logic ov;
    if (sub) begin
      ov = (a[15] != b[15]) && (raw[15] != a[15]);
    end else begin
      ov = (a[15] == b[15]) && (raw[15] != a[15]);
    end
    return ov;
  endfunction

endpackage

// File: rtl/addsub_16bit.sv
// Combinational signed 16-bit add/subtract with clamping to the signed range.
module addsub_16bit
  import sat_accum_16bit_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);

  logic [15:0] raw_s;
  logic        ovfl_s;

  // On overflow the true result lies beyond the range on the side of a's sign.
  always_comb begin
    raw_s  = sub ? (a - b) : (a + b);
    ovfl_s = sat_ovfl(a, b, sub, raw_s);
    if (ovfl_s) begin
      sum = a[15] ? SAT_NEG : SAT_POS;
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/sat_accum_16bit.sv
// Packet-folding saturating accumulator with a registered valid/ready result port.
module sat_accum_16bit
  import sat_accum_16bit_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_sub,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovfl,
  output logic        out_zero,
  output logic        out_neg,
  output logic        out_len_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_r, state_nxt;
  logic [15:0]       acc_r, acc_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic              ovfl_r, ovfl_nxt;
  logic              len_err_r, len_err_nxt;
  logic              valid_r, valid_nxt;
  logic              ready_r, ready_nxt;
  logic              zero_r, zero_nxt;
  logic              neg_r, neg_nxt;
  logic              busy_r, busy_nxt;

  logic [15:0]       base_s;
  logic [15:0]       nxt_s;
  logic [15:0]       raw_s;
  logic              beat_ovfl_s;
  logic              accept_s;

  assign base_s   = (state_r == ACCUM) ? acc_r : 16'h0000;
  assign accept_s = in_valid && (state_r != DONE);

  addsub_16bit u_addsub (
    .a   (base_s),
    .b   (in_data),
    .sub (in_sub),
    .sum (nxt_s)
  );

  // The adder only exports the clamped sum, so the overflow flag is rebuilt here.
  assign raw_s       = in_sub ? (base_s - in_data) : (base_s + in_data);
  assign beat_ovfl_s = sat_ovfl(base_s, in_data, in_sub, raw_s);

  // Next-state, datapath and result-flag logic.
  always_comb begin
    state_nxt   = state_r;
    acc_nxt     = acc_r;
    cnt_nxt     = cnt_r;
    ovfl_nxt    = ovfl_r;
    len_err_nxt = len_err_r;
    valid_nxt   = valid_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          acc_nxt     = nxt_s;
          ovfl_nxt    = beat_ovfl_s;
          cnt_nxt     = CNT_ONE;
          len_err_nxt = 1'b0;
          if (in_last) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_nxt  = nxt_s;
          ovfl_nxt = ovfl_r | beat_ovfl_s;
          cnt_nxt  = cnt_r + CNT_ONE;
          if (in_last) begin
            state_nxt = DONE;
            valid_nxt = 1'b1;
          end else if (cnt_nxt == CNT_MAX) begin
            state_nxt   = DONE;
            valid_nxt   = 1'b1;
            len_err_nxt = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end else begin
          state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt   = IDLE;
          acc_nxt     = 16'h0000;
          cnt_nxt     = '0;
          ovfl_nxt    = 1'b0;
          len_err_nxt = 1'b0;
          valid_nxt   = 1'b0;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        acc_nxt     = 16'h0000;
        cnt_nxt     = '0;
        ovfl_nxt    = 1'b0;
        len_err_nxt = 1'b0;
        valid_nxt   = 1'b0;
      end
    endcase
    zero_nxt  = valid_nxt && (acc_nxt == 16'h0000);
    neg_nxt   = valid_nxt && acc_nxt[15];
    ready_nxt = (state_nxt != DONE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      acc_r     <= 16'h0000;
      cnt_r     <= '0;
      ovfl_r    <= 1'b0;
      len_err_r <= 1'b0;
      valid_r   <= 1'b0;
      ready_r   <= 1'b1;
      zero_r    <= 1'b0;
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      acc_r     <= acc_nxt;
      cnt_r     <= cnt_nxt;
      ovfl_r    <= ovfl_nxt;
      len_err_r <= len_err_nxt;
      valid_r   <= valid_nxt;
      ready_r   <= ready_nxt;
      zero_r    <= zero_nxt;
      neg_r     <= neg_nxt;
      busy_r    <= busy_nxt;
    end
  end

  assign in_ready    = ready_r;
  assign out_valid   = valid_r;
  assign out_data    = acc_r;
  assign out_ovfl    = ovfl_r;
  assign out_zero    = zero_r;
  assign out_neg     = neg_r;
  assign out_len_err = len_err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_sat_accum_16bit.sv
// Directed self-checking bench for sat_accum_16bit with hand-computed expectations.
module tb_sat_accum_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_sub = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovfl;
  logic        out_zero;
  logic        out_neg;
  logic        out_len_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sat_accum_16bit #(.MAX_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovfl(out_ovfl), .out_zero(out_zero), .out_neg(out_neg),
    .out_len_err(out_len_err), .busy(busy)
  );

  task automatic send(input logic [15:0] d, input logic s, input logic l);
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    vectors++; if ({out_ovfl, out_zero, out_neg, out_len_err, busy} !== 5'b00000) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {out_ovfl, out_zero, out_neg, out_len_err, busy}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    send(16'h0005, 1'b0, 1'b0);
    vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_mid busy=%b valid=%b want 1 0", busy, out_valid); end
    send(16'h000A, 1'b0, 1'b0);
    send(16'h0003, 1'b1, 1'b1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h000C) begin miscompares++; $display("FAIL basic_data got %h want 000c", out_data); end
    vectors++; if ({out_ovfl, out_zero, out_neg, out_len_err} !== 4'b0000) begin miscompares++; $display("FAIL basic_flags got %b want 0000", {out_ovfl, out_zero, out_neg, out_len_err}); end
    ack();
  endtask

  task automatic test_saturation();
    send(16'h7000, 1'b0, 1'b0);
    send(16'h2000, 1'b0, 1'b1);
    vectors++; if (out_data !== 16'h7FFF || out_ovfl !== 1'b1 || out_neg !== 1'b0) begin miscompares++; $display("FAIL pos_sat got %h ovfl=%b neg=%b want 7fff 1 0", out_data, out_ovfl, out_neg); end
    ack();
    send(16'h9000, 1'b0, 1'b0);
    send(16'hE000, 1'b0, 1'b1);
    vectors++; if (out_data !== 16'h8000 || out_ovfl !== 1'b1 || out_neg !== 1'b1) begin miscompares++; $display("FAIL neg_sat got %h ovfl=%b neg=%b want 8000 1 1", out_data, out_ovfl, out_neg); end
    ack();
  endtask

  task automatic test_sticky();
    send(16'h8000, 1'b1, 1'b0);
    vectors++; if (out_data !== 16'h7FFF) begin miscompares++; $display("FAIL sticky_step1 got %h want 7fff", out_data); end
    send(16'h0001, 1'b0, 1'b0);
    vectors++; if (out_data !== 16'h7FFF) begin miscompares++; $display("FAIL sticky_step2 got %h want 7fff", out_data); end
    send(16'hFFFF, 1'b0, 1'b1);
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h7FFE || out_ovfl !== 1'b1) begin miscompares++; $display("FAIL sticky_final got v=%b %h ovfl=%b want 1 7ffe 1", out_valid, out_data, out_ovfl); end
    ack();
  endtask

  task automatic test_backpressure();
    send(16'h0020, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 16'h1234; in_sub = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0020 || out_ovfl !== 1'b0 || out_zero !== 1'b0) begin
        miscompares++; $display("FAIL stall_%0d got rdy=%b v=%b %h ovfl=%b z=%b want 0 1 0020 0 0", i, in_ready, out_valid, out_data, out_ovfl, out_zero);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    ack();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL release got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL release_clear got %h want 0000", out_data); end
  endtask

  task automatic test_len_err();
    for (int i = 0; i < 15; i++) send(16'h0001, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL len_15 got valid=%b want 0", out_valid); end
    send(16'h0001, 1'b0, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_len_err !== 1'b1) begin miscompares++; $display("FAIL len_16 got v=%b %h lerr=%b want 1 0010 1", out_valid, out_data, out_len_err); end
    ack();
    send(16'h0000, 1'b0, 1'b1);
    vectors++; if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_len_err !== 1'b0 || out_data !== 16'h0000) begin miscompares++; $display("FAIL zero_beat got v=%b z=%b lerr=%b %h want 1 1 0 0000", out_valid, out_zero, out_len_err, out_data); end
    ack();
  endtask

  task automatic test_mid_reset();
    send(16'h0005, 1'b0, 1'b0);
    send(16'h0006, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_ctl got rdy=%b v=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    vectors++; if (out_data !== 16'h0000 || {out_ovfl, out_zero, out_neg, out_len_err} !== 4'b0000) begin miscompares++; $display("FAIL midrst_data got %h flags=%b want 0000 0000", out_data, {out_ovfl, out_zero, out_neg, out_len_err}); end
    send(16'h0004, 1'b0, 1'b1);
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h0004) begin miscompares++; $display("FAIL midrst_new got v=%b %h want 1 0004", out_valid, out_data); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_saturation();
    test_sticky();
    test_backpressure();
    test_len_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
